// File: rtl/dual_deque_pkg.sv
// rtl/dual_deque_pkg.sv - shared types and constants for the dual deque controller
//
// Holds the command op encodings, the controller FSM state type, the depths of
// the two deques behind the controller, and the command legality rule.

package dual_deque_pkg;

    // Command op field, 2 bits per requester.
    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_MOVE = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_MPUSH   = 2'b11
    } state_e;

    // Word capacity of each deque.
    localparam int D0_DEPTH = 16;
    localparam int D1_DEPTH = 15;

    // A command is legal when the target (or, for MOVE, source and destination)
    // can take the operation given the flags seen at acceptance.
    function automatic logic cmd_legal(
        input op_e  op,
        input logic tgt_empty,
        input logic tgt_full,
        input logic other_full
    );
        case (op)
            OP_PUSH: return !tgt_full;
            OP_POP:  return !tgt_empty;
            OP_MOVE: return !tgt_empty && !other_full;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dual_deque_ctrl_if.sv
// rtl/dual_deque_ctrl_if.sv - requester command / response bundle
//
// Signals (per-requester fields packed with requester A in the low slice):
//   req_valid[1:0]     command valid
//   req_ready[1:0]     command accept, one-hot or zero
//   req_op[3:0]        2-bit op per requester
//   req_deque[1:0]     target deque (MOVE: source)
//   req_end[1:0]       end select (MOVE: source end)
//   req_dst_end[1:0]   MOVE destination end
//   req_data[2*DW-1:0] push data
//   resp_valid/id/err/data  one-cycle response
// Modports: master = requester side, slave = controller side.

interface dual_deque_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [3:0]          req_op;
    logic [1:0]          req_deque;
    logic [1:0]          req_end;
    logic [1:0]          req_dst_end;
    logic [2*DATA_W-1:0] req_data;
    logic                resp_valid;
    logic                resp_id;
    logic                resp_err;
    logic [DATA_W-1:0]   resp_data;

    modport master (
        output req_valid, req_op, req_deque, req_end, req_dst_end, req_data,
        input  req_ready, resp_valid, resp_id, resp_err, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_deque, req_end, req_dst_end, req_data,
        output req_ready, resp_valid, resp_id, resp_err, resp_data
    );
endinterface

// File: rtl/dual_deque_rr_arb.sv
// rtl/dual_deque_rr_arb.sv - two-way round-robin / fixed-priority arbiter
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_i[1:0]    requests (bit 0 = A, bit 1 = B)
//   accept_i      the current grant was taken this cycle
//   gnt_o[1:0]    one-hot grant, combinational from req_i and the pointer
// FIXED_PRIO=1 makes A win whenever it requests.

module dual_deque_rr_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // ptr_q = 0 favours A on a tie, 1 favours B.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (FIXED_PRIO != 0) begin
            if (req_i[0]) begin
                gnt_o = 2'b01;
            end else if (req_i[1]) begin
                gnt_o = 2'b10;
            end
        end else if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    // After a grant the other requester gets the next tie.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dual_deque_ctrl.sv
// rtl/dual_deque_ctrl.sv - command controller and arbiter for the dual deque
//
// Ports:
//   clk, rst                synchronous active-high reset
//   bus                     requester command/response bundle (slave side)
//   dq_deque_select         0 = deque 0 (16 words), 1 = deque 1 (15 words)
//   dq_end_select           end select passed to the deque
//   dq_push, dq_pop         single-cycle strobes, never both high
//   dq_data_in              write data to the deque
//   dq_data_out             read data, valid the cycle after dq_pop
//   d0/d1_empty, d0/d1_full deque status flags
// Responses: PUSH and errors one cycle after acceptance, POP two, MOVE three.

module dual_deque_ctrl
    import dual_deque_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    dual_deque_ctrl_if.slave  bus,
    output logic              dq_deque_select,
    output logic              dq_end_select,
    output logic              dq_push,
    output logic              dq_pop,
    output logic [DATA_W-1:0] dq_data_in,
    input  logic [DATA_W-1:0] dq_data_out,
    input  logic              d0_empty,
    input  logic              d0_full,
    input  logic              d1_empty,
    input  logic              d1_full
);

    // Arbitration and the winning command's fields.
    logic [1:0]        gnt;
    logic              accept;
    logic              win_id;
    op_e               win_op;
    logic              win_deque;
    logic              win_end;
    logic              win_dst_end;
    logic [DATA_W-1:0] win_data;
    logic              tgt_empty;
    logic              tgt_full;
    logic              other_full;
    logic              win_legal;

    // Latched command.
    state_e            state_q;
    op_e               op_q;
    logic              deque_q;
    logic              dst_end_q;
    logic              id_q;
    logic              chain_q;

    // Registered outputs.
    logic              dq_push_q;
    logic              dq_pop_q;
    logic              dq_sel_q;
    logic              dq_end_q;
    logic [DATA_W-1:0] dq_data_in_q;
    logic              resp_valid_q;
    logic              resp_id_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              pop_resp_q;

    dual_deque_rr_arb #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (bus.req_valid),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // Ready is withheld while rst is high so no command is lost to reset.
    assign bus.req_ready = (state_q == ST_IDLE && !rst) ? gnt : 2'b00;
    assign accept        = |(bus.req_valid & bus.req_ready);

    always_comb begin
        win_id      = gnt[1];
        win_op      = op_e'(win_id ? bus.req_op[3:2] : bus.req_op[1:0]);
        win_deque   = bus.req_deque[win_id];
        win_end     = bus.req_end[win_id];
        win_dst_end = bus.req_dst_end[win_id];
        win_data    = win_id ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
        tgt_empty   = win_deque ? d1_empty : d0_empty;
        tgt_full    = win_deque ? d1_full  : d0_full;
        other_full  = win_deque ? d0_full  : d1_full;
        win_legal   = cmd_legal(win_op, tgt_empty, tgt_full, other_full);
    end

    // Outputs are registered on entry to the state that owns them, so each
    // strobe/response is visible during the cycle the state is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_PUSH;
            deque_q      <= 1'b0;
            dst_end_q    <= 1'b0;
            id_q         <= 1'b0;
            chain_q      <= 1'b0;
            dq_push_q    <= 1'b0;
            dq_pop_q     <= 1'b0;
            dq_sel_q     <= 1'b0;
            dq_end_q     <= 1'b0;
            dq_data_in_q <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            pop_resp_q   <= 1'b0;
        end else begin
            dq_push_q    <= 1'b0;
            dq_pop_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            pop_resp_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q   <= ST_ISSUE;
                        op_q      <= win_op;
                        deque_q   <= win_deque;
                        dst_end_q <= win_dst_end;
                        id_q      <= win_id;
                        chain_q   <= win_legal && (win_op != OP_PUSH);
                        if (!win_legal) begin
                            resp_valid_q <= 1'b1;
                            resp_id_q    <= win_id;
                            resp_err_q   <= 1'b1;
                        end else if (win_op == OP_PUSH) begin
                            dq_push_q    <= 1'b1;
                            dq_sel_q     <= win_deque;
                            dq_end_q     <= win_end;
                            dq_data_in_q <= win_data;
                            resp_valid_q <= 1'b1;
                            resp_id_q    <= win_id;
                        end else begin
                            dq_pop_q <= 1'b1;
                            dq_sel_q <= win_deque;
                            dq_end_q <= win_end;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (chain_q) begin
                        state_q <= ST_CAPTURE;
                        if (op_q == OP_POP) begin
                            resp_valid_q <= 1'b1;
                            resp_id_q    <= id_q;
                            pop_resp_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (op_q == OP_MOVE) begin
                        state_q      <= ST_MPUSH;
                        dq_push_q    <= 1'b1;
                        dq_sel_q     <= ~deque_q;
                        dq_end_q     <= dst_end_q;
                        dq_data_in_q <= dq_data_out;
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= id_q;
                        resp_data_q  <= dq_data_out;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MPUSH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dq_push         = dq_push_q;
    assign dq_pop          = dq_pop_q;
    assign dq_deque_select = dq_sel_q;
    assign dq_end_select   = dq_end_q;
    assign dq_data_in      = dq_data_in_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_err    = resp_err_q;
    // The popped byte only becomes valid in the CAPTURE cycle itself, so a
    // POP response forwards the deque output directly during that cycle.
    assign bus.resp_data   = pop_resp_q ? dq_data_out : resp_data_q;

endmodule

// File: tb/tb_dual_deque_ctrl.sv
// tb/tb_dual_deque_ctrl.sv - directed self-checking bench for dual_deque_ctrl

module tb_dual_deque_ctrl;
    import dual_deque_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_deque_ctrl_if #(.DATA_W(8)) bus ();
    dual_deque_ctrl_if #(.DATA_W(8)) bus_f ();

    logic       dq_deque_select, dq_end_select, dq_push, dq_pop;
    logic [7:0] dq_data_in;
    logic [7:0] dq_data_out = 8'h00;
    logic       d0_empty, d0_full, d1_empty, d1_full;

    logic       f_dq_deque_select, f_dq_end_select, f_dq_push, f_dq_pop;
    logic [7:0] f_dq_data_in;

    int n_checks = 0;
    int n_fail   = 0;

    dual_deque_ctrl #(.DATA_W(8), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .dq_deque_select(dq_deque_select), .dq_end_select(dq_end_select),
        .dq_push(dq_push), .dq_pop(dq_pop), .dq_data_in(dq_data_in),
        .dq_data_out(dq_data_out),
        .d0_empty(d0_empty), .d0_full(d0_full), .d1_empty(d1_empty), .d1_full(d1_full)
    );

    // Fixed-priority instance sees the same requests; its deques never fill or empty.
    dual_deque_ctrl #(.DATA_W(8), .FIXED_PRIO(1)) dut_f (
        .clk(clk), .rst(rst), .bus(bus_f),
        .dq_deque_select(f_dq_deque_select), .dq_end_select(f_dq_end_select),
        .dq_push(f_dq_push), .dq_pop(f_dq_pop), .dq_data_in(f_dq_data_in),
        .dq_data_out(8'h00),
        .d0_empty(1'b0), .d0_full(1'b0), .d1_empty(1'b0), .d1_full(1'b0)
    );

    assign bus_f.req_valid   = bus.req_valid;
    assign bus_f.req_op      = bus.req_op;
    assign bus_f.req_deque   = bus.req_deque;
    assign bus_f.req_end     = bus.req_end;
    assign bus_f.req_dst_end = bus.req_dst_end;
    assign bus_f.req_data    = bus.req_data;

    // Deque model: end 0 = front, 1 = back; read data registered on pop.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int cnt0 = 0;
    int cnt1 = 0;
    assign d0_empty = (cnt0 == 0);
    assign d0_full  = (cnt0 == D0_DEPTH);
    assign d1_empty = (cnt1 == 0);
    assign d1_full  = (cnt1 == D1_DEPTH);

    always @(posedge clk) begin
        if (dq_push) begin
            if (!dq_deque_select) begin
                if (dq_end_select) q0.push_back(dq_data_in); else q0.push_front(dq_data_in);
                cnt0 <= cnt0 + 1;
            end else begin
                if (dq_end_select) q1.push_back(dq_data_in); else q1.push_front(dq_data_in);
                cnt1 <= cnt1 + 1;
            end
        end
        if (dq_pop) begin
            if (!dq_deque_select && q0.size() > 0) begin
                if (dq_end_select) dq_data_out <= q0.pop_back(); else dq_data_out <= q0.pop_front();
                cnt0 <= cnt0 - 1;
            end else if (dq_deque_select && q1.size() > 0) begin
                if (dq_end_select) dq_data_out <= q1.pop_back(); else dq_data_out <= q1.pop_front();
                cnt1 <= cnt1 - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_resp(input string tag, input logic v, input logic id,
                              input logic err, input logic [7:0] data);
        check_eq({tag, ".resp_valid"}, bus.resp_valid, v);
        if (v) check_eq({tag, ".resp_id"}, bus.resp_id, id);
        check_eq({tag, ".resp_err"}, bus.resp_err, err);
        check_eq({tag, ".resp_data"}, bus.resp_data, data);
    endtask

    task automatic check_strobe(input string tag, input logic push, input logic pop,
                                input logic sel, input logic en);
        check_eq({tag, ".dq_push"}, dq_push, push);
        check_eq({tag, ".dq_pop"}, dq_pop, pop);
        check_eq({tag, ".dq_deque_select"}, dq_deque_select, sel);
        check_eq({tag, ".dq_end_select"}, dq_end_select, en);
    endtask

    // Presents a command and returns at the negedge of the cycle after acceptance.
    task automatic send(input int id, input logic [1:0] op, input logic dq,
                        input logic en, input logic dst, input logic [7:0] data);
        int waited = 0;
        @(negedge clk);
        bus.req_op[2*id +: 2]   = op;
        bus.req_deque[id]       = dq;
        bus.req_end[id]         = en;
        bus.req_dst_end[id]     = dst;
        bus.req_data[8*id +: 8] = data;
        bus.req_valid[id]       = 1'b1;
        #1;
        while (!bus.req_ready[id] && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) check_eq("accept_timeout", 32'(waited), 32'(0));
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid   = 2'b00;
        bus.req_op      = 4'h0;
        bus.req_deque   = 2'b00;
        bus.req_end     = 2'b00;
        bus.req_dst_end = 2'b00;
        bus.req_data    = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset.req_ready", bus.req_ready, 2'b00);
        check_strobe("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset.dq_data_in", dq_data_in, 8'h00);
        check_resp("reset", 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;

        // A PUSH 0x5A to d0 front: strobe and response at N+1, single pulse
        send(0, OP_PUSH, 1'b0, 1'b0, 1'b0, 8'h5A);
        check_strobe("push5a", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("push5a.dq_data_in", dq_data_in, 8'h5A);
        check_resp("push5a", 1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_eq("push5a.pulse", dq_push, 1'b0);
        check_eq("push5a.resp_pulse", bus.resp_valid, 1'b0);

        // B POP empty d1: error at N+1, no pop strobe
        send(1, OP_POP, 1'b1, 1'b0, 1'b0, 8'h00);
        check_resp("pop_empty", 1'b1, 1'b1, 1'b1, 8'h00);
        check_strobe("pop_empty", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("pop_empty.no_pop", dq_pop, 1'b0);

        // d0 = [5A, 11]; A POP d0 back -> 0x11 at N+2
        send(0, OP_PUSH, 1'b0, 1'b1, 1'b0, 8'h11);
        send(0, OP_POP, 1'b0, 1'b1, 1'b0, 8'h00);
        check_strobe("pop11.n1", 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("pop11.n1.resp_valid", bus.resp_valid, 1'b0);
        @(negedge clk);
        check_eq("pop11.n2.dq_pop", dq_pop, 1'b0);
        check_resp("pop11.n2", 1'b1, 1'b0, 1'b0, 8'h11);

        // d0 = [22, 5A]; B MOVE d0 front -> d1 back
        send(0, OP_PUSH, 1'b0, 1'b0, 1'b0, 8'h22);
        send(1, OP_MOVE, 1'b0, 1'b0, 1'b1, 8'h00);
        check_strobe("move.n1", 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("move.n1.resp_valid", bus.resp_valid, 1'b0);
        @(negedge clk);
        check_eq("move.n2.dq_push", dq_push, 1'b0);
        check_eq("move.n2.dq_pop", dq_pop, 1'b0);
        check_eq("move.n2.resp_valid", bus.resp_valid, 1'b0);
        @(negedge clk);
        check_strobe("move.n3", 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("move.n3.dq_data_in", dq_data_in, 8'h22);
        check_resp("move.n3", 1'b1, 1'b1, 1'b0, 8'h22);

        // Both requesters hold PUSH valid: main alternates A,B,A,B; fixed grants A only
        repeat (5) @(negedge clk);
        bus.req_op          = {OP_PUSH, OP_PUSH};
        bus.req_deque       = 2'b10;
        bus.req_end         = 2'b11;
        bus.req_data        = 16'hB1A1;
        bus.req_valid       = 2'b11;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (i % 2 == 0) begin
                check_eq($sformatf("rr.grant%0d", i / 2), bus.req_ready,
                         (i % 4 == 0) ? 2'b01 : 2'b10);
                check_eq($sformatf("fixed.grant%0d", i / 2), bus_f.req_ready, 2'b01);
            end else begin
                check_eq($sformatf("fixed.push%0d", i / 2), f_dq_push, 1'b1);
                check_eq($sformatf("fixed.id%0d", i / 2), bus_f.resp_id, 1'b0);
                check_eq($sformatf("fixed.rv%0d", i / 2), bus_f.resp_valid, 1'b1);
                check_eq($sformatf("fixed.wr%0d", i / 2),
                         {f_dq_deque_select, f_dq_end_select, f_dq_data_in}, {2'b01, 8'hA1});
                check_eq($sformatf("fixed.quiet%0d", i / 2),
                         {f_dq_pop, bus_f.resp_err, bus_f.resp_data}, 10'h000);
            end
        end
        bus.req_valid = 2'b00;

        // Reserved op is rejected
        send(0, OP_RSVD, 1'b1, 1'b0, 1'b0, 8'h00);
        check_resp("rsvd", 1'b1, 1'b0, 1'b1, 8'h00);
        check_eq("rsvd.dq_push", dq_push, 1'b0);

        // d0 holds 3 words; 13 more fill it, the next push is rejected
        for (int i = 0; i < 13; i++) begin
            send(0, OP_PUSH, 1'b0, 1'b1, 1'b0, 8'h30 + 8'(i));
            if (i == 12) begin
                check_resp("fill16", 1'b1, 1'b0, 1'b0, 8'h00);
                check_eq("fill16.dq_push", dq_push, 1'b1);
            end
        end
        send(0, OP_PUSH, 1'b0, 1'b1, 1'b0, 8'hEE);
        check_resp("push17", 1'b1, 1'b0, 1'b1, 8'h00);
        check_eq("push17.dq_push", dq_push, 1'b0);

        // Reset during MOVE CAPTURE: no MPUSH, no response, ready next cycle
        send(1, OP_MOVE, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("rstmove.n1.dq_pop", dq_pop, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_strobe("rstmove.after", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rstmove.after.resp_valid", bus.resp_valid, 1'b0);
        bus.req_op[1:0]   = OP_PUSH;
        bus.req_deque[0]  = 1'b1;
        bus.req_end[0]    = 1'b0;
        bus.req_data[7:0] = 8'h77;
        bus.req_valid[0]  = 1'b1;
        #1;
        check_eq("rstmove.req_ready", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        check_strobe("rstmove.push77", 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("rstmove.push77.data", dq_data_in, 8'h77);
        check_resp("rstmove.push77", 1'b1, 1'b0, 1'b0, 8'h00);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
